// File: rtl/ss_mac_seq_ctrl.sv
// Job sequencer for the 4-bit stochastic-symbol MAC: per-lane LFSRs, round-robin lane select,
// accumulator clear control and result capture. Optional wrap detection under SS_MAC_OVF_DET_EN.
module ss_mac_seq_ctrl #(
    parameter int NUM_IN = 8,
    parameter int SEL_W  = 3,
    parameter int RAND_W = 8,
    parameter int ITER_W = 8,
    parameter int ACC_W  = 10
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     start_i,
    input  logic [ITER_W-1:0]        iter_cnt_i,
    output logic                     busy_o,
    output logic                     done_o,
    output logic [SEL_W-1:0]         sel_o,
    output logic [NUM_IN*RAND_W-1:0] rand_bus_o,
    output logic                     mac_clr_n_o,
    input  logic [ACC_W-1:0]         mac_acc_i,
    output logic [ACC_W-1:0]         result_o
`ifdef SS_MAC_OVF_DET_EN
    ,
    output logic                     ovf_o
`endif
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    typedef logic [NUM_IN-1:0][RAND_W-1:0] lanes_t;

    function automatic lanes_t seed_vec();
        lanes_t v;
        for (int i = 0; i < NUM_IN; i++) begin
            v[i] = RAND_W'(8'hA5 ^ 8'(i * 'h1D));
        end
        return v;
    endfunction

    localparam lanes_t SEEDS = seed_vec();

    logic [1:0]        state_q, state_d;
    logic [SEL_W-1:0]  sel_q, sel_d;
    logic [ITER_W-1:0] pass_q, pass_d;
    logic [ITER_W-1:0] iter_q, iter_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              clr_n_q, clr_n_d;
    logic [ACC_W-1:0]  result_q, result_d;
    lanes_t            lfsr_q, lfsr_d, lfsr_step;

    // Fibonacci x^8+x^6+x^5+x^4+1, shift left, feedback into bit 0
    always_comb begin
        for (int i = 0; i < NUM_IN; i++) begin
            lfsr_step[i] = {lfsr_q[i][RAND_W-2:0],
                            lfsr_q[i][RAND_W-1] ^ lfsr_q[i][RAND_W-3] ^
                            lfsr_q[i][RAND_W-4] ^ lfsr_q[i][RAND_W-5]};
        end
    end

`ifdef SS_MAC_OVF_DET_EN
    logic [ACC_W-1:0] prev_q, prev_d;
    logic             first_q, first_d;
    logic             flag_q, flag_d;
    logic             ovf_q, ovf_d;
    logic             wrap_now;

    // First RUN cycle has no valid predecessor sample, so it never flags.
    assign wrap_now = !first_q && (mac_acc_i < prev_q);
`endif

    always_comb begin
        state_d  = state_q;
        sel_d    = sel_q;
        pass_d   = pass_q;
        iter_d   = iter_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        clr_n_d  = clr_n_q;
        result_d = result_q;
        lfsr_d   = lfsr_q;
`ifdef SS_MAC_OVF_DET_EN
        prev_d   = prev_q;
        first_d  = first_q;
        flag_d   = flag_q;
        ovf_d    = ovf_q;
`endif
        case (state_q)
            S_IDLE: begin
                sel_d   = '0;
                clr_n_d = 1'b0;
                busy_d  = 1'b0;
                if (start_i) begin
                    busy_d = 1'b1;
`ifdef SS_MAC_OVF_DET_EN
                    ovf_d   = 1'b0;
                    flag_d  = 1'b0;
                    first_d = 1'b1;
`endif
                    if (iter_cnt_i != '0) begin
                        state_d = S_RUN;
                        iter_d  = iter_cnt_i;
                        pass_d  = '0;
                        lfsr_d  = SEEDS;
                        clr_n_d = 1'b1;
                    end else begin
                        state_d  = S_DONE;
                        result_d = '0;
                        done_d   = 1'b1;
                    end
                end
            end
            S_RUN: begin
                lfsr_d = lfsr_step;
                sel_d  = sel_q + SEL_W'(1);
`ifdef SS_MAC_OVF_DET_EN
                prev_d  = mac_acc_i;
                first_d = 1'b0;
                flag_d  = flag_q | wrap_now;
`endif
                if (sel_q == SEL_W'(NUM_IN - 1)) begin
                    sel_d  = '0;
                    pass_d = pass_q + ITER_W'(1);
                    if (pass_q == iter_q - ITER_W'(1)) state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                sel_d   = '0;
                state_d = S_DONE;
                done_d  = 1'b1;
                clr_n_d = 1'b0;
`ifdef SS_MAC_OVF_DET_EN
                prev_d = mac_acc_i;
                flag_d = flag_q | wrap_now;
                if (flag_q | wrap_now) begin
                    result_d = '1;
                    ovf_d    = 1'b1;
                end else begin
                    result_d = mac_acc_i;
                    ovf_d    = 1'b0;
                end
`else
                result_d = mac_acc_i;
`endif
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
                clr_n_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= S_IDLE;
            sel_q    <= '0;
            pass_q   <= '0;
            iter_q   <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            clr_n_q  <= 1'b0;
            result_q <= '0;
            lfsr_q   <= SEEDS;
`ifdef SS_MAC_OVF_DET_EN
            prev_q   <= '0;
            first_q  <= 1'b1;
            flag_q   <= 1'b0;
            ovf_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            sel_q    <= sel_d;
            pass_q   <= pass_d;
            iter_q   <= iter_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            clr_n_q  <= clr_n_d;
            result_q <= result_d;
            lfsr_q   <= lfsr_d;
`ifdef SS_MAC_OVF_DET_EN
            prev_q   <= prev_d;
            first_q  <= first_d;
            flag_q   <= flag_d;
            ovf_q    <= ovf_d;
`endif
        end
    end

    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign sel_o       = sel_q;
    assign rand_bus_o  = lfsr_q;
    assign mac_clr_n_o = clr_n_q;
    assign result_o    = result_q;
`ifdef SS_MAC_OVF_DET_EN
    assign ovf_o       = ovf_q;
`endif

endmodule

// File: tb/tb_ss_mac_seq_ctrl.sv
// Directed bench for ss_mac_seq_ctrl with an accumulator stub and a result scoreboard.
module tb_ss_mac_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  iter_cnt = '0;
    logic        busy, done, mac_clr_n;
    logic [2:0]  sel;
    logic [63:0] rand_bus;
    logic [9:0]  mac_acc = '0;
    logic [9:0]  result;
    logic [9:0]  add_val = 10'd3;
`ifdef SS_MAC_OVF_DET_EN
    logic        ovf;
`endif

    int checks = 0;
    int errors = 0;
    logic [9:0] exp_q[$];

    ss_mac_seq_ctrl dut (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start), .iter_cnt_i(iter_cnt),
        .busy_o(busy), .done_o(done), .sel_o(sel), .rand_bus_o(rand_bus),
        .mac_clr_n_o(mac_clr_n), .mac_acc_i(mac_acc), .result_o(result)
`ifdef SS_MAC_OVF_DET_EN
        , .ovf_o(ovf)
`endif
    );

    always #5 clk = ~clk;

    // MAC stub: synchronous clear while mac_clr_n is low, else add a fixed symbol
    always @(posedge clk) begin
        if (!mac_clr_n) mac_acc <= '0;
        else            mac_acc <= mac_acc + add_val;
    end

    function automatic logic [7:0] lane(input int i);
        return rand_bus[i*8 +: 8];
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Called #1 after an edge; start is sampled by the next edge.
    task automatic run_job(input int n, input logic [9:0] exp_res, input int poke, input bit lfsr_chk);
        int dc;
        bit distinct;
        logic [9:0] r;
        start = 1'b1;
        iter_cnt = n[7:0];
        exp_q.push_back(exp_res);
        step();
        start = 1'b0;
        dc = (n == 0) ? 1 : 8 * n + 2;
        distinct = 1'b1;
        for (int c = 1; c < dc; c++) begin
            chk("done_low", done, 0);
            chk("busy_run", busy, 1);
            chk("clr_n_run", mac_clr_n, 1);
            if (c <= 8 * n) chk("sel_seq", sel, (c - 1) % 8);
            else            chk("sel_drain", sel, 0);
            if (lfsr_chk) begin
                for (int i = 0; i < 8; i++)
                    for (int j = i + 1; j < 8; j++)
                        if (lane(i) == lane(j)) distinct = 1'b0;
                if (c == 1) begin
                    chk("lane0_seed", lane(0), 8'hA5);
                    chk("lane7_seed", lane(7), 8'h6E);
                end
                if (c == 2)   chk("lane0_step1", lane(0), 8'h4A);
                if (c == 256) chk("lane0_step255", lane(0), 8'hA5);
            end
            if (c == poke) begin
                start = 1'b1;
                iter_cnt = 8'd5;
            end else begin
                start = 1'b0;
            end
            step();
        end
        start = 1'b0;
        if (lfsr_chk) chk("lanes_distinct", distinct, 1);
        chk("done_pulse", done, 1);
        chk("busy_done", busy, 1);
        chk("clr_n_done", mac_clr_n, 0);
        chk("sel_done", sel, 0);
        if (exp_q.size() == 0) begin
            chk("scoreboard_empty", 0, 1);
            r = '0;
        end else begin
            r = exp_q.pop_front();
        end
        chk("result", result, r);
        step();
        chk("done_after", done, 0);
        chk("busy_after", busy, 0);
        chk("result_held", result, r);
    endtask

    initial begin
        bit seen_done;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (10) step();
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_clr_n", mac_clr_n, 0);
        chk("rst_sel", sel, 0);
        chk("rst_result", result, 0);
        chk("rst_lane0", lane(0), 8'hA5);
        chk("rst_lane1", lane(1), 8'hB8);

        add_val = 10'd3;
        run_job(2, 10'd48, 0, 1'b0);
        repeat (3) step();
        chk("result_idle_hold", result, 48);

        run_job(0, 10'd0, 0, 1'b0);
        chk("zero_clr_n", mac_clr_n, 0);
        chk("zero_sel", sel, 0);

        run_job(2, 10'd48, 5, 1'b0);
        seen_done = 1'b0;
        for (int k = 0; k < 20; k++) begin
            if (busy || done) seen_done = 1'b1;
            step();
        end
        chk("busy_start_ignored", seen_done, 0);

        run_job(32, 10'd768, 0, 1'b1);

        start = 1'b1;
        iter_cnt = 8'd4;
        step();
        start = 1'b0;
        repeat (10) step();
        chk("midjob_busy", busy, 1);
        rst_n = 1'b0;
        #2;
        chk("midrst_busy", busy, 0);
        chk("midrst_result", result, 0);
        chk("midrst_clr_n", mac_clr_n, 0);
        chk("midrst_sel", sel, 0);
        chk("midrst_done", done, 0);
        chk("midrst_lane0", lane(0), 8'hA5);
        @(negedge clk);
        rst_n = 1'b1;
        seen_done = 1'b0;
        for (int k = 0; k < 40; k++) begin
            step();
            if (done || busy) seen_done = 1'b1;
        end
        chk("midrst_no_done", seen_done, 0);

`ifdef SS_MAC_OVF_DET_EN
        add_val = 10'd15;
        run_job(9, 10'h3FF, 0, 1'b0);
        chk("ovf_set", ovf, 1);
        run_job(8, 10'd960, 0, 1'b0);
        chk("ovf_clear", ovf, 0);
`endif

        chk("scoreboard_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
